// File: rtl/ibex_irq_gen.sv
// Interrupt requester for the ibex core. Qualifies raw sources as edge or level,
// holds edge events until the core acknowledges them, and runs NMI acknowledge/holdoff.
module ibex_irq_gen #(
  parameter logic [17:0] EdgeMask   = 18'h07FFF,
  parameter int unsigned NmiHoldoff = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [17:0] src_i,
  input  logic        nmi_src_i,
  input  logic        en_we_i,
  input  logic [17:0] en_wdata_i,
  input  logic        ack_valid_i,
  input  logic [5:0]  ack_cause_i,
  output logic [17:0] irq_o,
  output logic        irq_nm_o,
  output logic [17:0] pending_o
);

  localparam int unsigned NumIrq = 18;
  localparam int unsigned CntW   = 8;
  localparam logic [CntW-1:0] HoldLoad =
      (NmiHoldoff == 0) ? '0 : CntW'(NmiHoldoff - 1);

  typedef enum logic [1:0] {
    NmiIdle = 2'd0,
    NmiPend = 2'd1,
    NmiHold = 2'd2
  } nmi_state_e;

  logic [NumIrq-1:0] src_q, pend_q, pend_d, en_q, en_d;
  logic [NumIrq-1:0] ack_clr, src_edge;
  logic              nmi_q, nmi_edge, ack_nmi, irq_nm_q;
  logic [CntW-1:0]   hold_q, hold_d;
  nmi_state_e        state_q, state_d;

  // Map an acknowledged exception cause onto the source it retires.
  always_comb begin
    ack_clr = '0;
    ack_nmi = 1'b0;
    if (ack_valid_i && ack_cause_i[5]) begin
      case (ack_cause_i[4:0])
        5'd3:    ack_clr[17] = 1'b1;
        5'd7:    ack_clr[16] = 1'b1;
        5'd11:   ack_clr[15] = 1'b1;
        5'd31:   ack_nmi     = 1'b1;
        default: if (ack_cause_i[4]) ack_clr[ack_cause_i[3:0]] = 1'b1;
      endcase
    end
  end

  // A new edge beats a same-cycle ack, so nothing raised in that cycle is lost.
  assign src_edge = src_i & ~src_q;
  assign pend_d   = (EdgeMask & (src_edge | (pend_q & ~ack_clr))) | (~EdgeMask & src_i);
  assign en_d     = en_we_i ? en_wdata_i : en_q;
  assign nmi_edge = nmi_src_i & ~nmi_q;

  // NMI next-state: edges merge while pending and are dropped during holdoff.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      NmiIdle: if (nmi_edge) state_d = NmiPend;
      NmiPend: begin
        if (ack_nmi) begin
          if (NmiHoldoff == 0) begin
            state_d = NmiIdle;
          end else begin
            state_d = NmiHold;
            hold_d  = HoldLoad;
          end
        end
      end
      NmiHold: begin
        if (hold_q == '0) state_d = NmiIdle;
        else              hold_d  = hold_q - 8'd1;
      end
      default: state_d = NmiIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q    <= '0;
      nmi_q    <= 1'b0;
      pend_q   <= '0;
      en_q     <= '0;
      hold_q   <= '0;
      state_q  <= NmiIdle;
      irq_nm_q <= 1'b0;
    end else begin
      src_q    <= src_i;
      nmi_q    <= nmi_src_i;
      pend_q   <= pend_d;
      en_q     <= en_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
      irq_nm_q <= (state_d == NmiPend);
    end
  end

  assign irq_o     = pend_q & en_q;
  assign pending_o = pend_q;
  assign irq_nm_o  = irq_nm_q;

endmodule

// File: tb/tb_ibex_irq_gen.sv
// Bench for ibex_irq_gen: directed vector table, NMI holdoff sequences and
// randomized traffic, all checked against an event/timestamp reference model.
module tb_ibex_irq_gen;

  localparam logic [17:0] EDGE_MASK = 18'h07FFF;
  localparam int          HOLDOFF   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] src;
  logic        nmi;
  logic        en_we;
  logic [17:0] en_wd;
  logic        ack_v;
  logic [5:0]  ack_c;
  logic [17:0] irq, pend;
  logic        irq_nm;

  int checks = 0;
  int errors = 0;

  ibex_irq_gen #(.EdgeMask(EDGE_MASK), .NmiHoldoff(HOLDOFF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .nmi_src_i(nmi),
    .en_we_i(en_we), .en_wdata_i(en_wd), .ack_valid_i(ack_v), .ack_cause_i(ack_c),
    .irq_o(irq), .irq_nm_o(irq_nm), .pending_o(pend)
  );

  always #5 clk = ~clk;

  // Reference model: pending set, enable set, NMI flag and a "blocked until" timestamp.
  logic [17:0] m_pend, m_en, m_prev;
  bit          m_nprev, m_npend;
  int          m_block, cyc;

  function automatic int cause_bit(input logic [5:0] c);
    if (c == 6'h23) return 17;
    if (c == 6'h27) return 16;
    if (c == 6'h2B) return 15;
    if (c == 6'h3F) return 18;
    if (c >= 6'h30 && c <= 6'h3E) return int'(c) - 48;
    return -1;
  endfunction

  task automatic model_step();
    int b;
    cyc++;
    if (!rst_n) begin
      m_pend = '0; m_en = '0; m_prev = '0; m_nprev = 0; m_npend = 0; m_block = -1000;
      return;
    end
    b = ack_v ? cause_bit(ack_c) : -1;
    for (int i = 0; i < 18; i++) begin
      if (EDGE_MASK[i]) begin
        if (src[i] && !m_prev[i]) m_pend[i] = 1'b1;
        else if (b == i)          m_pend[i] = 1'b0;
      end else begin
        m_pend[i] = src[i];
      end
    end
    if (en_we) m_en = en_wd;
    m_prev = src;
    if (m_npend && b == 18) begin
      m_npend = 0;
      m_block = cyc + HOLDOFF;
    end else if (!m_npend && nmi && !m_nprev && cyc > m_block) begin
      m_npend = 1;
    end
    m_nprev = nmi;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input logic [17:0] s, input bit n, input bit we,
                      input logic [17:0] wd, input bit av, input logic [5:0] c);
    rst_n = r; src = s; nmi = n; en_we = we; en_wd = wd; ack_v = av; ack_c = c;
    @(posedge clk);
    model_step();
    #1;
    chk("model_irq", 32'(irq), 32'(m_pend & m_en));
    chk("model_pending", 32'(pend), 32'(m_pend));
    chk("model_nm", 32'(irq_nm), 32'(m_npend));
  endtask

  typedef struct {
    bit          r;
    logic [17:0] s;
    bit          n;
    bit          we;
    logic [17:0] wd;
    bit          av;
    logic [5:0]  c;
    logic [17:0] e_irq;
    logic [17:0] e_pend;
    bit          e_nm;
  } vec_t;

  function automatic vec_t mk(bit r, logic [17:0] s, bit n, bit we, logic [17:0] wd,
                              bit av, logic [5:0] c, logic [17:0] ei, logic [17:0] ep, bit en);
    vec_t v;
    v.r = r; v.s = s; v.n = n; v.we = we; v.wd = wd; v.av = av; v.c = c;
    v.e_irq = ei; v.e_pend = ep; v.e_nm = en;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    cyc = 0; m_block = -1000;
    m_pend = '0; m_en = '0; m_prev = '0; m_nprev = 0; m_npend = 0;
    rst_n = 0; src = '0; nmi = 0; en_we = 0; en_wd = '0; ack_v = 0; ack_c = '0;

    //               rst src       nmi we wdata     av cause  irq       pend      nm
    tbl[0]  = mk(0, 18'h0,     0, 0, 18'h0,     0, 6'h00, 18'h0,     18'h0,     0);
    tbl[1]  = mk(1, 18'h0,     0, 1, 18'h3FFFF, 0, 6'h00, 18'h0,     18'h0,     0);
    tbl[2]  = mk(1, 18'h8,     0, 0, 18'h0,     0, 6'h00, 18'h8,     18'h8,     0);
    tbl[3]  = mk(1, 18'h0,     0, 0, 18'h0,     0, 6'h00, 18'h8,     18'h8,     0);
    tbl[4]  = mk(1, 18'h0,     0, 0, 18'h0,     1, 6'h33, 18'h0,     18'h0,     0);
    tbl[5]  = mk(1, 18'h0,     0, 0, 18'h0,     0, 6'h00, 18'h0,     18'h0,     0);
    tbl[6]  = mk(1, 18'h10000, 0, 0, 18'h0,     0, 6'h00, 18'h10000, 18'h10000, 0);
    tbl[7]  = mk(1, 18'h10000, 0, 0, 18'h0,     1, 6'h27, 18'h10000, 18'h10000, 0);
    tbl[8]  = mk(1, 18'h10000, 0, 0, 18'h0,     0, 6'h00, 18'h10000, 18'h10000, 0);
    tbl[9]  = mk(1, 18'h0,     0, 0, 18'h0,     0, 6'h00, 18'h0,     18'h0,     0);
    tbl[10] = mk(1, 18'h0,     0, 1, 18'h0,     0, 6'h00, 18'h0,     18'h0,     0);
    tbl[11] = mk(1, 18'h1,     0, 0, 18'h0,     0, 6'h00, 18'h0,     18'h1,     0);
    tbl[12] = mk(1, 18'h0,     0, 1, 18'h1,     0, 6'h00, 18'h1,     18'h1,     0);
    tbl[13] = mk(1, 18'h0,     0, 1, 18'h3FFFF, 1, 6'h30, 18'h0,     18'h0,     0);
    tbl[14] = mk(1, 18'h20,    0, 0, 18'h0,     0, 6'h00, 18'h20,    18'h20,    0);
    tbl[15] = mk(1, 18'h0,     0, 0, 18'h0,     0, 6'h00, 18'h20,    18'h20,    0);
    tbl[16] = mk(1, 18'h20,    0, 0, 18'h0,     1, 6'h35, 18'h20,    18'h20,    0);
    tbl[17] = mk(1, 18'h0,     0, 0, 18'h0,     1, 6'h05, 18'h20,    18'h20,    0);
    tbl[18] = mk(1, 18'h0,     0, 0, 18'h0,     1, 6'h21, 18'h20,    18'h20,    0);
    tbl[19] = mk(1, 18'h0,     0, 0, 18'h0,     1, 6'h35, 18'h0,     18'h0,     0);
    tbl[20] = mk(1, 18'h2000C, 0, 0, 18'h0,     0, 6'h00, 18'h2000C, 18'h2000C, 0);
    tbl[21] = mk(1, 18'h0,     0, 0, 18'h0,     0, 6'h00, 18'hC,     18'hC,     0);
    tbl[22] = mk(1, 18'h0,     1, 0, 18'h0,     0, 6'h00, 18'hC,     18'hC,     1);
    tbl[23] = mk(1, 18'h4,     1, 0, 18'h0,     0, 6'h00, 18'hC,     18'hC,     1);
    tbl[24] = mk(0, 18'h4,     0, 0, 18'h0,     0, 6'h00, 18'h0,     18'h0,     0);
    tbl[25] = mk(1, 18'h4,     0, 0, 18'h0,     0, 6'h00, 18'h0,     18'h4,     0);
    tbl[26] = mk(1, 18'h4,     0, 1, 18'h4,     0, 6'h00, 18'h4,     18'h4,     0);
    tbl[27] = mk(1, 18'h0,     0, 1, 18'h3FFFF, 1, 6'h32, 18'h0,     18'h0,     0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].n, tbl[i].we, tbl[i].wd, tbl[i].av, tbl[i].c);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].e_irq));
      chk($sformatf("vec%0d_pending", i), 32'(pend), 32'(tbl[i].e_pend));
      chk($sformatf("vec%0d_nm", i), 32'(irq_nm), 32'(tbl[i].e_nm));
    end

    // NMI holdoff: edge at ack+2 dropped, edge at ack+5 accepted.
    step(1, '0, 1, 0, '0, 0, 6'h00); chk("nmi_rise", 32'(irq_nm), 32'd1);
    step(1, '0, 0, 0, '0, 0, 6'h00); chk("nmi_hold_high", 32'(irq_nm), 32'd1);
    step(1, '0, 0, 0, '0, 1, 6'h3F); chk("nmi_ack_fall", 32'(irq_nm), 32'd0);
    step(1, '0, 0, 0, '0, 0, 6'h00); chk("nmi_ack1", 32'(irq_nm), 32'd0);
    step(1, '0, 1, 0, '0, 0, 6'h00); chk("nmi_drop_ack2", 32'(irq_nm), 32'd0);
    step(1, '0, 0, 0, '0, 0, 6'h00); chk("nmi_ack3", 32'(irq_nm), 32'd0);
    step(1, '0, 0, 0, '0, 0, 6'h00); chk("nmi_ack4", 32'(irq_nm), 32'd0);
    step(1, '0, 1, 0, '0, 0, 6'h00); chk("nmi_accept_ack5", 32'(irq_nm), 32'd1);
    // Boundary: edge at ack+4 is still dropped, ack+6 accepted.
    step(1, '0, 0, 0, '0, 1, 6'h3F); chk("nmi_ack_b", 32'(irq_nm), 32'd0);
    for (int k = 1; k <= 3; k++) step(1, '0, 0, 0, '0, 0, 6'h00);
    step(1, '0, 1, 0, '0, 0, 6'h00); chk("nmi_drop_ack4", 32'(irq_nm), 32'd0);
    step(1, '0, 0, 0, '0, 0, 6'h00); chk("nmi_still_low", 32'(irq_nm), 32'd0);
    step(1, '0, 1, 0, '0, 0, 6'h00); chk("nmi_accept_ack6", 32'(irq_nm), 32'd1);
    // Reset while NMI pending clears it.
    step(0, '0, 1, 0, '0, 0, 6'h00); chk("nmi_reset", 32'(irq_nm), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic [5:0] c;
      int sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: c = 6'h23;
        1: c = 6'h27;
        2: c = 6'h2B;
        3: c = 6'h3F;
        4: c = 6'(6'h30 + $urandom_range(0, 14));
        default: c = 6'($urandom);
      endcase
      step(($urandom_range(0, 59) != 0), 18'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0), 18'($urandom),
           1'($urandom), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
